// File: rtl/fetch_stage_if.sv
// Purpose: bundles the fetch stage's instruction-memory bus, the decode-side
//          stall/redirect controls and the registered IF/ID slot outputs.
// Ports (master = fetch stage side):
//   imem_addr/imem_rd out, imem_data in        instruction memory (async read)
//   stall/redirect_valid/redirect_pc in        decode-stage control
//   if_valid/if_opcode/if_rdst/if_rsrc/
//   if_imm/if_pc_next out                      IF/ID slot
interface fetch_stage_if #(
  parameter int unsigned PC_W    = 32,
  parameter int unsigned INSTR_W = 16
);
  localparam int unsigned OP_W  = 9;
  localparam int unsigned REG_W = 3;

  logic [PC_W-1:0]    imem_addr;
  logic               imem_rd;
  logic [INSTR_W-1:0] imem_data;

  logic               stall;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;

  logic               if_valid;
  logic [OP_W-1:0]    if_opcode;
  logic [REG_W-1:0]   if_rdst;
  logic [REG_W-1:0]   if_rsrc;
  logic [INSTR_W-1:0] if_imm;
  logic [PC_W-1:0]    if_pc_next;

  modport master (
    output imem_addr, imem_rd,
    input  imem_data,
    input  stall, redirect_valid, redirect_pc,
    output if_valid, if_opcode, if_rdst, if_rsrc, if_imm, if_pc_next
  );

  modport slave (
    input  imem_addr, imem_rd,
    output imem_data,
    output stall, redirect_valid, redirect_pc,
    input  if_valid, if_opcode, if_rdst, if_rsrc, if_imm, if_pc_next
  );
endinterface

// File: rtl/fetch_stage.sv
// Purpose: instruction-fetch stage. Loads the 32-bit reset vector from words 0/1,
//          sequences the PC, assembles one- or two-word instructions and presents
//          them in a registered IF/ID slot. Honours stall and redirect (flush).
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    fetch_stage_if.master (memory bus, stall/redirect, IF/ID slot)
module fetch_stage #(
  parameter int unsigned PC_W    = 32,
  parameter int unsigned INSTR_W = 16
) (
  input logic           clk,
  input logic           rst_n,
  fetch_stage_if.master bus
);

  localparam int unsigned OP_W   = 9;
  localparam int unsigned REG_W  = 3;
  localparam int unsigned HOLD_W = INSTR_W - 1;

  typedef enum logic [1:0] {
    BOOT_HI = 2'd0,
    BOOT_LO = 2'd1,
    FETCH   = 2'd2,
    IMM     = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [PC_W-1:0]     addr_q, addr_d;
  logic [PC_W-1:0]     pc_inc;
  // First word of a two-word instruction, without its imm flag bit
  logic [HOLD_W-1:0]   hold_q, hold_d;

  logic                valid_q, valid_d;
  logic [OP_W-1:0]     opcode_q, opcode_d;
  logic [REG_W-1:0]    rdst_q, rdst_d;
  logic [REG_W-1:0]    rsrc_q, rsrc_d;
  logic [INSTR_W-1:0]  imm_q, imm_d;
  logic [PC_W-1:0]     pc_next_q, pc_next_d;

  assign pc_inc = pc_q + PC_W'(1);

  // Next-state, PC sequencing and IF/ID slot update
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    hold_d    = hold_q;
    valid_d   = valid_q;
    opcode_d  = opcode_q;
    rdst_d    = rdst_q;
    rsrc_d    = rsrc_q;
    imm_d     = imm_q;
    pc_next_d = pc_next_q;

    case (state_q)
      BOOT_HI: begin
        pc_d    = {(PC_W-16)'(bus.imem_data), pc_q[15:0]};
        state_d = BOOT_LO;
      end

      BOOT_LO: begin
        pc_d    = {pc_q[PC_W-1:16], bus.imem_data};
        state_d = FETCH;
      end

      FETCH: begin
        if (bus.redirect_valid) begin
          pc_d     = bus.redirect_pc;
          valid_d  = 1'b0;
          opcode_d = '0;
          rdst_d   = '0;
          rsrc_d   = '0;
          imm_d    = '0;
        end else if (!bus.stall) begin
          pc_d = pc_inc;
          if (bus.imem_data[0]) begin
            // Two-word instruction: park the first word, emit a bubble
            hold_d   = bus.imem_data[INSTR_W-1:1];
            valid_d  = 1'b0;
            opcode_d = '0;
            rdst_d   = '0;
            rsrc_d   = '0;
            imm_d    = '0;
            state_d  = IMM;
          end else begin
            valid_d   = 1'b1;
            opcode_d  = bus.imem_data[15:7];
            rdst_d    = bus.imem_data[6:4];
            rsrc_d    = bus.imem_data[3:1];
            imm_d     = '0;
            pc_next_d = pc_inc;
          end
        end
      end

      IMM: begin
        if (bus.redirect_valid) begin
          pc_d     = bus.redirect_pc;
          hold_d   = '0;
          valid_d  = 1'b0;
          opcode_d = '0;
          rdst_d   = '0;
          rsrc_d   = '0;
          imm_d    = '0;
          state_d  = FETCH;
        end else if (!bus.stall) begin
          valid_d   = 1'b1;
          opcode_d  = hold_q[14:6];
          rdst_d    = hold_q[5:3];
          rsrc_d    = hold_q[2:0];
          imm_d     = bus.imem_data;
          pc_next_d = pc_inc;
          pc_d      = pc_inc;
          state_d   = FETCH;
        end
      end

      default: state_d = BOOT_HI;
    endcase

    // Memory address is registered; it follows the state/PC being entered
    case (state_d)
      BOOT_HI: addr_d = '0;
      BOOT_LO: addr_d = PC_W'(1);
      default: addr_d = pc_d;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BOOT_HI;
      pc_q      <= '0;
      addr_q    <= '0;
      hold_q    <= '0;
      valid_q   <= 1'b0;
      opcode_q  <= '0;
      rdst_q    <= '0;
      rsrc_q    <= '0;
      imm_q     <= '0;
      pc_next_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      hold_q    <= hold_d;
      valid_q   <= valid_d;
      opcode_q  <= opcode_d;
      rdst_q    <= rdst_d;
      rsrc_q    <= rsrc_d;
      imm_q     <= imm_d;
      pc_next_q <= pc_next_d;
    end
  end

  // Every state reads memory; the read strobe is low only while held in reset
  assign bus.imem_rd    = rst_n;
  assign bus.imem_addr  = addr_q;
  assign bus.if_valid   = valid_q;
  assign bus.if_opcode  = opcode_q;
  assign bus.if_rdst    = rdst_q;
  assign bus.if_rsrc    = rsrc_q;
  assign bus.if_imm     = imm_q;
  assign bus.if_pc_next = pc_next_q;

endmodule
